// File: rtl/xnor_pkg.sv
// Shared types and constants for the XNOR conv output path.
// Packer state encoding and conv geometry live here.
package xnor_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 12;
    localparam int MIN_DIM    = 3;
    localparam int CONV_K     = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PACK = 1'b1
    } pack_state_e;

    typedef logic [15:0] dim_t;

    // Valid 3x3 conv shrinks each side by K-1
    function automatic dim_t row_len_of(dim_t d);
        return d - dim_t'(CONV_K - 1);
    endfunction

endpackage

// File: rtl/output_packer_if.sv
// Result-bit stream in, packed SRAM write port out.
// master drives the bit stream; slave is the packer.
interface output_packer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
);
    logic              in_valid;
    logic              in_bit;
    logic              sram_write_en;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;

    modport master (
        output in_valid,
        output in_bit,
        input  sram_write_en,
        input  sram_addr,
        input  sram_wdata
    );

    modport slave (
        input  in_valid,
        input  in_bit,
        output sram_write_en,
        output sram_addr,
        output sram_wdata
    );
endinterface

// File: rtl/output_packer_word_shifter.sv
// LSB-first bit accumulator; word_o is the word including
// the bit being loaded this cycle.
module word_shifter #(
    parameter int DATA_W = 16,
    localparam int BW    = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic              bit_i,
    input  logic [BW-1:0]     pos_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] word_o
);
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic [DATA_W-1:0] base;
    logic [DATA_W-1:0] mask;

    always_comb begin
        base = clr_i ? '0 : shift_q;
        mask = DATA_W'(1) << pos_i;
        word_o = base;
        if (load_i && bit_i) begin
            word_o = base | mask;
        end
        shift_d = flush_i ? '0 : word_o;
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end
endmodule

// File: rtl/output_packer.sv
// Packs the per-cycle conv result bits into SRAM words,
// one or more words per output row, row ends always flush.
module output_packer
    import xnor_pkg::*;
#(
    parameter int                DATA_W    = DATA_W_DEF,
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              frame_start,
    input  logic [15:0]       dim,
    output_packer_if.slave    bus,
    output logic              frame_done,
    output logic [ADDR_W-1:0] words_written,
    output logic              dim_err,
    output logic              busy
);
    localparam int BW = $clog2(DATA_W);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    pack_state_e       state_q, state_d;
    dim_t              row_len_q, row_len_d;
    dim_t              col_q, col_d;
    dim_t              row_q, row_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] words_q, words_d;
    logic              err_q, err_d;
    logic              busy_q;

    logic              start_ok;
    logic              acc;
    logic              row_end;
    logic              flush;
    logic              last;
    dim_t              eff_len;
    dim_t              eff_col;
    dim_t              eff_row;
    logic [BW-1:0]     eff_bit;
    logic [DATA_W-1:0] word;

    word_shifter #(
        .DATA_W (DATA_W)
    ) u_shift (
        .clk     (clk),
        .reset_b (reset_b),
        .clr_i   (frame_start),
        .load_i  (acc),
        .bit_i   (bus.in_bit),
        .pos_i   (eff_bit),
        .flush_i (flush),
        .word_o  (word)
    );

    // frame_start clears first; a same-cycle bit lands in the new frame
    always_comb begin
        start_ok = frame_start && (dim >= dim_t'(MIN_DIM));
        eff_len  = start_ok ? row_len_of(dim) : row_len_q;
        eff_col  = frame_start ? '0 : col_q;
        eff_row  = frame_start ? '0 : row_q;
        eff_bit  = frame_start ? '0 : bit_q;

        acc = bus.in_valid &&
              (start_ok || (state_q == ST_PACK && !frame_start));
        row_end = eff_col == eff_len - 16'd1;
        flush = acc && (row_end || eff_bit == BIT_LAST);
        last = acc && row_end && (eff_row == eff_len - 16'd1);

        row_len_d = eff_len;
        bit_d = eff_bit;
        col_d = eff_col;
        row_d = eff_row;
        if (acc) begin
            bit_d = flush ? '0 : eff_bit + BW'(1);
            col_d = row_end ? '0 : eff_col + 16'd1;
            if (row_end) begin
                row_d = last ? '0 : eff_row + 16'd1;
            end
        end

        state_d = state_q;
        if (frame_start) begin
            state_d = start_ok ? ST_PACK : ST_IDLE;
        end
        if (last) begin
            state_d = ST_IDLE;
        end

        addr_d = wr_q ? addr_q + ADDR_W'(1) : addr_q;
        if (start_ok) begin
            addr_d = BASE_ADDR;
        end

        words_d = (start_ok ? '0 : words_q) + ADDR_W'(flush);
        wr_d    = flush;
        wdata_d = flush ? word : wdata_q;
        done_d  = last;
        err_d   = frame_start ? !start_ok : err_q;
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q   <= ST_IDLE;
            row_len_q <= '0;
            col_q     <= '0;
            row_q     <= '0;
            bit_q     <= '0;
            wr_q      <= 1'b0;
            addr_q    <= BASE_ADDR;
            wdata_q   <= '0;
            done_q    <= 1'b0;
            words_q   <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_len_q <= row_len_d;
            col_q     <= col_d;
            row_q     <= row_d;
            bit_q     <= bit_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            done_q    <= done_d;
            words_q   <= words_d;
            err_q     <= err_d;
            busy_q    <= state_d == ST_PACK;
        end
    end

    assign bus.sram_write_en = wr_q;
    assign bus.sram_addr     = addr_q;
    assign bus.sram_wdata    = wdata_q;
    assign frame_done        = done_q;
    assign words_written     = words_q;
    assign dim_err           = err_q;
    assign busy              = busy_q;
endmodule

// File: tb/tb_output_packer.sv
// Directed bench for output_packer: two instances, the
// second with BASE_ADDR=FFE to exercise address wrap.
module tb_output_packer;

    logic        clk;
    logic        reset_b;
    logic        frame_start;
    logic [15:0] dim;
    logic        fd1, fd2;
    logic [11:0] ww1, ww2;
    logic        de1, de2;
    logic        bz1, bz2;

    output_packer_if #(.DATA_W(16), .ADDR_W(12)) bus ();
    output_packer_if #(.DATA_W(16), .ADDR_W(12)) bus2 ();

    assign bus2.in_valid = bus.in_valid;
    assign bus2.in_bit   = bus.in_bit;

    output_packer #(
        .DATA_W (16), .ADDR_W (12), .BASE_ADDR (12'h000)
    ) dut (
        .clk (clk), .reset_b (reset_b),
        .frame_start (frame_start), .dim (dim),
        .bus (bus),
        .frame_done (fd1), .words_written (ww1),
        .dim_err (de1), .busy (bz1)
    );

    output_packer #(
        .DATA_W (16), .ADDR_W (12), .BASE_ADDR (12'hFFE)
    ) dut2 (
        .clk (clk), .reset_b (reset_b),
        .frame_start (frame_start), .dim (dim),
        .bus (bus2),
        .frame_done (fd2), .words_written (ww2),
        .dim_err (de2), .busy (bz2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] a;
        logic [15:0] d;
        logic        done;
    } wr_t;

    wr_t q1[$];
    wr_t q2[$];
    int  ncmp = 0;
    int  nerr = 0;

    always @(negedge clk) begin
        if (bus.sram_write_en === 1'b1)
            q1.push_back('{bus.sram_addr, bus.sram_wdata, fd1});
        if (bus2.sram_write_en === 1'b1)
            q2.push_back('{bus2.sram_addr, bus2.sram_wdata, fd2});
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input bit second,
                          input int i, input logic [11:0] a,
                          input logic [15:0] d, input logic dn);
        wr_t w;
        w = '{12'hxxx, 16'hxxxx, 1'bx};
        if (!second && i < q1.size()) w = q1[i];
        if (second && i < q2.size()) w = q2[i];
        chk($sformatf("%s[%0d].addr", tag, i), 32'(w.a), 32'(a));
        chk($sformatf("%s[%0d].data", tag, i), 32'(w.d), 32'(d));
        chk($sformatf("%s[%0d].done", tag, i), 32'(w.done), 32'(dn));
    endtask

    task automatic start_frame(input logic [15:0] d);
        @(negedge clk);
        frame_start = 1'b1;
        dim = d;
        bus.in_valid = 1'b0;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic send(input logic b);
        bus.in_valid = 1'b1;
        bus.in_bit = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [15:0] pat;
        reset_b = 1'b0;
        frame_start = 1'b0;
        dim = '0;
        bus.in_valid = 1'b0;
        bus.in_bit = 1'b0;
        idle(2);
        chk("rst.wen", 32'(bus.sram_write_en), 0);
        chk("rst.addr", 32'(bus.sram_addr), 0);
        chk("rst.addr2", 32'(bus2.sram_addr), 32'h0FFE);
        chk("rst.wdata", 32'(bus.sram_wdata), 0);
        chk("rst.done", 32'(fd1), 0);
        chk("rst.words", 32'(ww1), 0);
        chk("rst.err", 32'(de1), 0);
        chk("rst.busy", 32'(bz1), 0);
        reset_b = 1'b1;
        idle(1);

        // dim=10: 8 rows of 8 bits, 1,0,1,0,... -> 0x0055
        q1.delete();
        start_frame(16'd10);
        chk("d10.busy", 32'(bz1), 1);
        for (int i = 0; i < 64; i++) begin
            send(i % 2 == 0);
            if (i == 7) begin
                chk("d10.lat.wen", 32'(bus.sram_write_en), 1);
                chk("d10.lat.data", 32'(bus.sram_wdata), 32'h55);
            end
        end
        idle(3);
        chk("d10.nwr", q1.size(), 8);
        for (int i = 0; i < 8; i++)
            chk_wr("d10", 0, i, 12'(i), 16'h0055, i == 7);
        chk("d10.words", 32'(ww1), 8);
        chk("d10.busy_end", 32'(bz1), 0);

        // dim=20: 18-bit rows of ones -> FFFF then 0003 per row
        q1.delete();
        start_frame(16'd20);
        for (int i = 0; i < 324; i++) send(1'b1);
        idle(3);
        chk("d20.nwr", q1.size(), 36);
        for (int i = 0; i < 36; i++)
            chk_wr("d20", 0, i, 12'(i),
                   (i % 2 == 0) ? 16'hFFFF : 16'h0003, i == 35);
        chk("d20.words", 32'(ww1), 36);

        // dim=18: exact 16-bit rows, gap in row 3
        q1.delete();
        start_frame(16'd18);
        for (int r = 0; r < 16; r++) begin
            pat = 16'hA5C3 ^ 16'(r);
            for (int b = 0; b < 16; b++) begin
                if (r == 3 && b == 7) idle(3);
                send(pat[b]);
            end
        end
        idle(3);
        chk("d18.nwr", q1.size(), 16);
        for (int r = 0; r < 16; r++)
            chk_wr("d18", 0, r, 12'(r), 16'hA5C3 ^ 16'(r), r == 15);
        chk("d18.words", 32'(ww1), 16);

        // dim=2 rejected, bits ignored
        q1.delete();
        start_frame(16'd2);
        chk("d2.err", 32'(de1), 1);
        chk("d2.busy", 32'(bz1), 0);
        for (int i = 0; i < 5; i++) send(1'b1);
        idle(2);
        chk("d2.nwr", q1.size(), 0);
        chk("d2.err_sticky", 32'(de1), 1);
        start_frame(16'd10);
        chk("d2.err_clr", 32'(de1), 0);
        chk("d2.words_clr", 32'(ww1), 0);
        chk("d2.addr_base", 32'(bus.sram_addr), 0);

        // abort after 5 bits of row 0, restart with 0,1,... -> 0x00AA
        for (int i = 0; i < 5; i++) send(1'b1);
        start_frame(16'd10);
        chk("abort.nwr0", q1.size(), 0);
        chk("abort.busy", 32'(bz1), 1);
        for (int i = 0; i < 64; i++) send(i % 2 == 1);
        idle(3);
        chk("abort.nwr", q1.size(), 8);
        for (int i = 0; i < 8; i++)
            chk_wr("abort", 0, i, 12'(i), 16'h00AA, i == 7);

        // BASE_ADDR=FFE instance wraps through 000
        q2.delete();
        start_frame(16'd10);
        chk("wrap.addr0", 32'(bus2.sram_addr), 32'h0FFE);
        for (int i = 0; i < 64; i++) send(i % 2 == 0);
        idle(3);
        chk("wrap.nwr", q2.size(), 8);
        for (int i = 0; i < 8; i++)
            chk_wr("wrap", 1, i, 12'hFFE + 12'(i), 16'h0055, i == 7);
        chk("wrap.words", 32'(ww2), 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nerr);
        $finish;
    end

endmodule
